// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with byte-enabled writes, optional hardwired
// zero register, same-cycle write bypass and a per-register busy scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       writeEnable,
    input  logic [ADDR_W-1:0]          writeAddress,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [DATA_W/8-1:0]        writeByteEnable,
    input  logic                       writeClearBusy,
    input  logic [NUM_READ*ADDR_W-1:0] readAddress,
    output logic [NUM_READ*DATA_W-1:0] readData,
    output logic [NUM_READ-1:0]        readBusy,
    input  logic                       issueValid,
    input  logic [ADDR_W-1:0]          issueAddress,
    output logic                       issueReady,
    output logic [DEPTH-1:0]           busyVector
);

    localparam int NBYTES = DATA_W / 8;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;

    logic write_ok;
    logic clear_ok;
    logic issue_zero;
    logic issue_fire;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] merged;
        merged = old_v;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Register 0 is a sink when hardwired: writes, clears and reservations to it vanish.
    assign write_ok   = writeEnable && !(ZERO_EN && (writeAddress == '0));
    assign clear_ok   = write_ok && writeClearBusy;
    assign issue_zero = ZERO_EN && (issueAddress == '0);
    assign issueReady = !busy_reg[issueAddress] || issue_zero;
    assign issue_fire = issueValid && issueReady && !issue_zero;

    // Set is applied after clear so a clear-flagged write to an idle register
    // cannot cancel a reservation accepted in the same cycle.
    always_comb begin
        busy_next = busy_reg;
        if (clear_ok) begin
            busy_next[writeAddress] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issueAddress] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            busy_reg <= busy_next;
            if (write_ok) begin
                regs_reg[writeAddress] <= byte_merge(regs_reg[writeAddress], writeData,
                                                     writeByteEnable);
            end
        end
    end

    assign busyVector = busy_reg;

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [ADDR_W-1:0] port_addr;
            logic [DATA_W-1:0] port_data;
            logic              port_busy;
            logic              port_hit;

            assign port_addr = readAddress[gi*ADDR_W +: ADDR_W];
            assign port_hit  = BYPASS_EN && write_ok && (writeAddress == port_addr);

            always_comb begin
                port_data = regs_reg[port_addr];
                port_busy = busy_reg[port_addr];
                if (ZERO_EN && (port_addr == '0)) begin
                    port_data = '0;
                    port_busy = 1'b0;
                end else if (port_hit) begin
                    port_data = byte_merge(regs_reg[port_addr], writeData, writeByteEnable);
                    port_busy = busy_reg[port_addr] && !writeClearBusy;
                end
            end

            assign readData[gi*DATA_W +: DATA_W] = port_data;
            assign readBusy[gi]                  = port_busy;
        end
    endgenerate

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the single-cycle 32×32 register file, providing the register file for the pipelined datapath. Adds configurable width, depth and read-port count, byte-enabled writes, a hardwired zero register, and same-cycle write-to-read bypass. A per-register busy scoreboard tracks outstanding multi-cycle results and gates new issues with a ready/valid handshake.

## Interface
Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- DEPTH, 32: number of registers; power of two, at least 2.
- ADDR_W, log2(DEPTH): address width, derived.
- NUM_READ, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: when 1, register 0 always reads 0 and is never written or marked busy.
- BYPASS, 1: when 1, same-cycle write data is forwarded to read ports.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- writeEnable  in  1  commit writeData to writeAddress at the clock edge.
- writeAddress  in  ADDR_W  destination register.
- writeData  in  DATA_W  data to write.
- writeByteEnable  in  DATA_W/8  per-byte write mask; bit k covers bits [8k+7:8k].
- writeClearBusy  in  1  when set with writeEnable, clears the busy bit of writeAddress.
- readAddress  in  NUM_READ*ADDR_W  packed read addresses; port p occupies slice p.
- readData  out  NUM_READ*DATA_W  packed read data, combinational.
- readBusy  out  NUM_READ  per-port busy flag for the addressed register.
- issueValid  in  1  request to reserve issueAddress for a pending result.
- issueAddress  in  ADDR_W  register to reserve.
- issueReady  out  1  reservation can be accepted this cycle.
- busyVector  out  DEPTH  registered busy bits, for debug and stall logic.

## Operation
- Storage: DEPTH × DATA_W flops. Busy: DEPTH flops.
- Write: at the rising edge with writeEnable=1, each byte with its enable bit set is updated and the other bytes hold. If ZERO_REG=1 and writeAddress=0, the write is dropped.
- Read, port p: raw = reg[readAddress_p]. If ZERO_REG=1 and the address is 0, output 0. Otherwise, if BYPASS=1, writeEnable=1 and writeAddress matches, output the byte-merge of writeData over raw. Otherwise output raw.
- readBusy_p = busy[addr_p], except:
  - 0 if the addressed register is register 0 and ZERO_REG=1.
  - 0 if BYPASS=1 and a writeEnable&writeClearBusy to the same address occurs this cycle.
- Scoreboard handshake:
  - issueReady = !busy[issueAddress], or 1 when issueAddress=0 and ZERO_REG=1.
  - Issue is accepted when issueValid & issueReady. The register's busy bit sets at the edge (not for register 0 when ZERO_REG=1).
  - An issue to a busy register is not accepted. The requester holds issueValid, and no state changes.
- Clear: writeEnable & writeClearBusy clears busy[writeAddress] at the edge.
- Simultaneous clear and issue to the same register: issueReady is computed from the registered busy bit, so it stays low and the issue stalls; the clear takes effect. Clear and issue to different registers both take effect.
- writeClearBusy without writeEnable is ignored.
- A write to a non-busy register with writeClearBusy=1 is legal and is a no-op on busy.

## Timing
- Reset (reset=0, asynchronous): all registers = 0 and all busy = 0. Resulting outputs: readData = 0, readBusy = 0, busyVector = 0, issueReady = 1. Reset mid-operation discards pending reservations immediately. The first edge after deassertion behaves normally.
- Write latency: 1 edge. Without bypass, a read in the same cycle returns the old value; with BYPASS=1 it returns the new value combinationally.
- Busy set/clear latency: 1 edge; busyVector updates after the edge.
- issueReady and readData/readBusy are combinational from inputs and state, with no clock-to-output register.
- All NUM_READ ports are independent. Multiple ports may address the same register.

## Test plan
- Reset then read: pulse reset low mid-cycle after writing reg 5=0xDEADBEEF -> reg 5 reads 0, busyVector=0, issueReady=1 immediately, before any clock edge.
- Byte write: write reg 3=0x11223344 (mask 0xF), then write 0xAABBCCDD with mask 0x5 -> reg 3 reads 0x11BB33DD.
- Bypass: in the same cycle, write reg 7=0xCAFEF00D (mask 0xF) and read port 1 addr 7 -> readData1=0xCAFEF00D before the edge. With BYPASS=0 -> returns the old value 0.
- Zero register: write reg 0=0xFFFFFFFF, issue to reg 0 -> reads 0, busyVector[0]=0, issueReady=1 throughout.
- Scoreboard: issue reg 9 -> busyVector[9]=1 next cycle. Issue reg 9 again -> issueReady=0 and no change. Write reg 9 with writeClearBusy -> readBusy=0 same cycle (bypass) and busy cleared after the edge. Re-issue accepted.
- Collision: same cycle clear reg 4 (busy) and issue reg 4 -> issue stalls and busy[4]=0 after the edge. Same cycle clear reg 4 and issue reg 6 -> busy[4]=0 and busy[6]=1.
